// File: rtl/count_seq_checker_pkg.sv
// Shared definitions for count_seq_checker: FSM state encoding and the
// default parameter values used by the checker and its error counter.
package count_seq_checker_pkg;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Default configuration
  localparam int CNT_W_DEF  = 3;
  localparam int ERR_W_DEF  = 8;
  localparam int LOCK_N_DEF = 2;

  // Saturating increment used by the error counter
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    sat_inc = (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_err_counter.sv
// sat_err_counter: sticky error flag plus a saturating error count with a
// synchronous clear. A clear that lands on the same edge as an error keeps
// that error, so the result is sticky=1 / cnt=1 rather than a lost event.
module sat_err_counter
  import count_seq_checker_pkg::*;
#(
  parameter int W = ERR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic         sticky,
  output logic [W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << W) - 64'd1);

  logic [31:0] cnt_ext;
  logic [W-1:0] cnt_inc;

  assign cnt_ext = 32'(cnt);
  assign cnt_inc = W'(sat_inc(cnt_ext, CNT_MAX));

  // Sticky flag and saturating count, clear has priority but never drops a new error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      sticky <= inc;
      cnt    <= inc ? W'(1) : '0;
    end else if (inc) begin
      sticky <= 1'b1;
      cnt    <= cnt_inc;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a free-running counter value q_in and checks
// that each valid sample is the previous one plus one (mod 2^CNT_W).
// It acquires lock after LOCK_N consecutive good steps, reports step errors
// only while locked, and flags wraps to zero while locked.
// Optional feature: define COUNT_SEQ_WRAP_CNT_EN to add the 8-bit wrap_cnt
// output and its register.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ERR_W  = ERR_W_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] q_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse
`ifdef COUNT_SEQ_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  // good never needs more than 3 bits since LOCK_N is limited to 1..7
  localparam logic [2:0] LOCK_N_C = 3'(LOCK_N);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] prev, prev_plus1;
  logic [2:0]       good, good_nxt;
  logic             step_ok;
  logic             err_evt;
  logic             wrap_evt;

  assign prev_plus1 = prev + 1'b1;
  assign step_ok    = (q_in == prev_plus1);

  // Next-state decode; nothing moves unless a sample is taken this cycle
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    err_evt   = 1'b0;
    wrap_evt  = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ACQ;
          good_nxt  = 3'd0;
        end
        ST_ACQ: begin
          if (step_ok) begin
            good_nxt = good + 3'd1;
            if (good_nxt >= LOCK_N_C) state_nxt = ST_LOCK;
          end else begin
            good_nxt = 3'd0;
          end
        end
        ST_LOCK: begin
          if (step_ok) begin
            wrap_evt = (q_in == '0);
          end else begin
            err_evt   = 1'b1;
            good_nxt  = 3'd0;
            state_nxt = ST_ACQ;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          good_nxt  = 3'd0;
        end
      endcase
    end
  end

  // FSM state, last sample and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      prev       <= '0;
      good       <= 3'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      good       <= good_nxt;
      if (en) prev <= q_in;
      locked     <= (state_nxt == ST_LOCK);
      err_pulse  <= err_evt;
      wrap_pulse <= wrap_evt;
    end
  end

  sat_err_counter #(
    .W(ERR_W)
  ) u_err (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (err_evt),
    .sticky(err_sticky),
    .cnt   (err_cnt)
  );

`ifdef COUNT_SEQ_WRAP_CNT_EN
  // Wrap counter rolls over naturally at 255 and ignores clr_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_cnt <= 8'd0;
    end else if (wrap_evt) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule
